// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped, read-only cache controller with line refill.
// Optional hit/miss statistics are enabled by defining CACHE_STATS_EN.
module dm_cache_ctrl #(
    parameter int ADDR_W         = 15,
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int INDEX_W        = 10
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cpu_req,
    input  logic [ADDR_W-1:0]                cpu_addr,
    input  logic                             flush,
    output logic                             cpu_ready,
    output logic [DATA_W-1:0]                cpu_rdata,
    output logic                             mem_req,
    output logic [ADDR_W-$clog2(WORDS_PER_LINE)-1:0] mem_addr,
    input  logic                             mem_ack,
    input  logic [WORDS_PER_LINE*DATA_W-1:0] mem_rdata,
    output logic [15:0]                      hit_count,
    output logic [15:0]                      miss_count
);

    localparam int OFF_W  = $clog2(WORDS_PER_LINE);
    localparam int TAG_W  = ADDR_W - INDEX_W - OFF_W;
    localparam int LINES  = 1 << INDEX_W;
    localparam int LINE_W = WORDS_PER_LINE * DATA_W;

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr_q;
    logic [LINES-1:0]    valid;
    logic [TAG_W-1:0]    tag_mem  [LINES];
    logic [LINE_W-1:0]   data_mem [LINES];

    logic [TAG_W-1:0]    tag_q;
    logic [INDEX_W-1:0]  idx_q;
    logic [OFF_W-1:0]    off_q;
    logic [LINE_W-1:0]   line_q;
    logic                hit;
    logic                do_flush, do_start, do_hit, do_miss, do_fill;

    assign tag_q  = addr_q[ADDR_W-1 -: TAG_W];
    assign idx_q  = addr_q[OFF_W +: INDEX_W];
    assign off_q  = addr_q[OFF_W-1:0];
    assign line_q = data_mem[idx_q];
    assign hit    = valid[idx_q] && (tag_mem[idx_q] == tag_q);

    // Next-state decode and the per-cycle action strobes.
    always_comb begin
        state_nxt = state;
        do_flush  = 1'b0;
        do_start  = 1'b0;
        do_hit    = 1'b0;
        do_miss   = 1'b0;
        do_fill   = 1'b0;
        case (state)
            IDLE: begin
                if (flush) begin
                    do_flush = 1'b1;
                end else if (cpu_req) begin
                    do_start  = 1'b1;
                    state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    do_hit    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    do_miss   = 1'b1;
                    state_nxt = REFILL;
                end
            end
            REFILL: begin
                if (mem_ack) begin
                    do_fill   = 1'b1;
                    state_nxt = LOOKUP;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Registered outputs, latched address and valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            valid     <= '0;
        end else begin
            cpu_ready <= do_hit;
            if (do_start) addr_q <= cpu_addr;
            if (do_hit)   cpu_rdata <= line_q[off_q*DATA_W +: DATA_W];
            if (do_miss) begin
                mem_req  <= 1'b1;
                mem_addr <= addr_q[ADDR_W-1:OFF_W];
            end
            if (do_fill) begin
                mem_req      <= 1'b0;
                valid[idx_q] <= 1'b1;
            end
            if (do_flush) valid <= '0;
        end
    end

    // Tag and data storage; contents are qualified by valid, so no reset.
    always_ff @(posedge clk) begin
        if (do_fill) begin
            tag_mem[idx_q]  <= tag_q;
            data_mem[idx_q] <= mem_rdata;
        end
    end

`ifdef CACHE_STATS_EN
    logic from_refill;

    // Saturating hit/miss counters; the hit that completes a refill is not a hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            from_refill <= 1'b0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            if (do_fill)            from_refill <= 1'b1;
            else if (state == LOOKUP) from_refill <= 1'b0;
            if (do_flush) begin
                hit_count  <= '0;
                miss_count <= '0;
            end else begin
                if (do_hit && !from_refill && hit_count != '1) hit_count <= hit_count + 16'd1;
                if (do_miss && miss_count != '1)               miss_count <= miss_count + 16'd1;
            end
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: randomized self-checking bench for dm_cache_ctrl.
// The reference model tracks which (index, tag) pairs are resident and what
// the hit/miss statistics must be; memory word at address a holds a.
module tb_dm_cache_ctrl;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;
    localparam int WPL    = 4;
    localparam int IDX_W  = 10;
    localparam int LADR_W = ADDR_W - 2;
`ifdef CACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  cpu_req = 1'b0;
    logic [ADDR_W-1:0]     cpu_addr = '0;
    logic                  flush = 1'b0;
    logic                  cpu_ready;
    logic [DATA_W-1:0]     cpu_rdata;
    logic                  mem_req;
    logic [LADR_W-1:0]     mem_addr;
    logic                  mem_ack = 1'b0;
    logic [WPL*DATA_W-1:0] mem_rdata = '0;
    logic [15:0]           hit_count;
    logic [15:0]           miss_count;

    int unsigned nchecks = 0;
    int unsigned nerrors = 0;

    // Reference model state.
    bit   [1023:0] mvalid;
    bit   [2:0]    mtag [1024];
    int unsigned   exp_hits, exp_misses;

    dm_cache_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS_PER_LINE(WPL), .INDEX_W(IDX_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .flush(flush), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [WPL*DATA_W-1:0] line_of(input logic [LADR_W-1:0] la);
        logic [WPL*DATA_W-1:0] l;
        for (int k = 0; k < WPL; k++) l[k*DATA_W +: DATA_W] = 32'(int'(la) * WPL + k);
        return l;
    endfunction

    task automatic model_clear();
        mvalid     = '0;
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_hits"},   64'(hit_count),  STATS ? 64'(exp_hits)   : 64'd0);
        check({tag, "_misses"}, 64'(miss_count), STATS ? 64'(exp_misses) : 64'd0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a);
        int unsigned idx, tg, ack_dly, wait_cnt, cyc_ready;
        bit exp_miss, saw_req, saw_ready;
        logic [DATA_W-1:0] got;
        idx = int'(a[11:2]);
        tg  = int'(a[14:12]);
        exp_miss = !(mvalid[idx] && mtag[idx] == 3'(tg));
        if (exp_miss) begin
            exp_misses++;
            mvalid[idx] = 1'b1;
            mtag[idx]   = 3'(tg);
        end else begin
            exp_hits++;
        end
        ack_dly   = $urandom_range(1, 4);
        wait_cnt  = 0;
        saw_req   = 1'b0;
        saw_ready = 1'b0;
        cyc_ready = 0;
        got       = '0;
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = a;
        @(posedge clk);
        #1;
        cpu_req  = 1'b0;
        cpu_addr = ADDR_W'($urandom);
        for (int cyc = 0; cyc < 40 && !saw_ready; cyc++) begin
            @(negedge clk);
            if (cpu_ready) begin
                saw_ready = 1'b1;
                cyc_ready = cyc;
                got       = cpu_rdata;
                mem_ack   = 1'b0;
            end else if (mem_req) begin
                saw_req = 1'b1;
                check("mem_addr", 64'(mem_addr), 64'(a[14:2]));
                wait_cnt++;
                if (wait_cnt == ack_dly) begin
                    mem_ack   = 1'b1;
                    mem_rdata = line_of(mem_addr);
                end else begin
                    mem_ack = 1'b0;
                end
            end else begin
                mem_ack = 1'b0;
            end
        end
        mem_ack = 1'b0;
        check("ready_seen", 64'(saw_ready), 64'd1);
        check("miss", 64'(saw_req), 64'(exp_miss));
        check("rdata", 64'(got), 64'(a));
        if (!exp_miss) check("hit_latency", 64'(cyc_ready), 64'd1);
        @(negedge clk);
        check("ready_pulse", 64'(cpu_ready), 64'd0);
        check("rdata_hold", 64'(cpu_rdata), 64'(a));
        check_counters("cnt");
    endtask

    task automatic do_flush(input bit with_req);
        @(negedge clk);
        flush    = 1'b1;
        cpu_req  = with_req;
        cpu_addr = ADDR_W'($urandom);
        @(posedge clk);
        #1;
        flush   = 1'b0;
        cpu_req = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        check("flush_no_req", 64'(mem_req), 64'd0);
        check("flush_no_ready", 64'(cpu_ready), 64'd0);
        check_counters("flush");
    endtask

    initial begin
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(cpu_ready), 64'd0);
        check("rst_rdata", 64'(cpu_rdata), 64'd0);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check_counters("rst");
        rst_n = 1'b1;

        // Directed sequence: fill, hits within the line, conflicting tag.
        do_read(15'd24);
        do_read(15'd25);
        do_read(15'd26);
        do_read(15'd27);
        do_read(15'd28);
        do_read(15'd24);
        do_read(15'd29);
        do_read(15'd4120);
        do_read(15'd24);
        do_flush(1'b0);
        do_read(15'd25);
        do_flush(1'b1);
        do_read(15'd26);

        // Reset while a refill is outstanding; a late ack must be ignored.
        apply_reset();
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = 15'd24;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("refill_req", 64'(mem_req), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_mem_req", 64'(mem_req), 64'd0);
        check("async_mem_addr", 64'(mem_addr), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = line_of(13'd6);
        @(negedge clk);
        mem_ack = 1'b0;
        check("late_ack_ready", 64'(cpu_ready), 64'd0);
        check("late_ack_req", 64'(mem_req), 64'd0);
        @(negedge clk);
        check("late_ack_ready2", 64'(cpu_ready), 64'd0);
        do_read(15'd24);

        // Randomized traffic over a small footprint to mix hits and misses.
        for (int n = 0; n < 300; n++) begin
            logic [2:0] tg;
            logic [9:0] ix;
            logic [1:0] of;
            tg = 3'($urandom_range(0, 7));
            ix = ($urandom_range(0, 3) == 0) ? 10'd1023 : 10'($urandom_range(0, 7));
            of = 2'($urandom);
            if ($urandom_range(0, 24) == 0) do_flush(1'($urandom));
            do_read({tg, ix, of});
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
